// File: rtl/io_bus_pkg.sv
// Shared opcodes, response codes and FSM state type for the register-bus initiator.
package io_bus_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] OP_BRD  = 8'h72;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_CNT,
    ST_GET_DATA,
    ST_BUS_WR,
    ST_BUS_RD,
    ST_RD_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/io_bus_initiator.sv
// Byte-command to peripheral-register-bus bridge: writes, single reads, burst reads.
// Define IO_BUS_WRITE_ACK_EN to return an ACK byte after every completed write.
module io_bus_initiator
  import io_bus_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] bus_address,
  output logic [7:0] bus_wdata,
  output logic       bus_w_en,
  output logic       bus_r_en,
  input  logic [7:0] bus_rdata,
  output logic       busy,
  output state_e     dbg_state
);

  // Streams: a byte moves on a cycle where valid && ready are both high; the
  // producer holds data/valid stable until then, ready never waits on valid.
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_e     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] beats_q, beats_d;
  logic [1:0] lat_q, lat_d;
  logic [7:0] rsp_data_q, rsp_data_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= 8'h00;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      beats_q    <= 8'h00;
      lat_q      <= 2'd0;
      rsp_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      beats_q    <= beats_d;
      lat_q      <= lat_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    beats_d    = beats_q;
    lat_d      = lat_q;
    rsp_data_d = rsp_data_q;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    bus_w_en   = 1'b0;
    bus_r_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = rst_n;
        if (cmd_valid) begin
          op_d    = cmd_data;
          beats_d = 8'd1;
          if (cmd_data == OP_WR || cmd_data == OP_RD || cmd_data == OP_BRD) begin
            state_d = ST_GET_ADDR;
          end else begin
            rsp_data_d = RSP_ERR;
            state_d    = ST_RESP;
          end
        end
      end
      ST_GET_ADDR: begin
        cmd_ready = rst_n;
        if (cmd_valid) begin
          addr_d = cmd_data;
          case (op_q)
            OP_WR:   state_d = ST_GET_DATA;
            OP_BRD:  state_d = ST_GET_CNT;
            default: state_d = ST_BUS_RD;
          endcase
        end
      end
      ST_GET_CNT: begin
        cmd_ready = rst_n;
        if (cmd_valid) begin
          beats_d = cmd_data;
          state_d = ST_BUS_RD;
        end
      end
      ST_GET_DATA: begin
        cmd_ready = rst_n;
        if (cmd_valid) begin
          wdata_d = cmd_data;
          state_d = ST_BUS_WR;
        end
      end
      ST_BUS_WR: begin
        bus_w_en = 1'b1;
`ifdef IO_BUS_WRITE_ACK_EN
        rsp_data_d = RSP_ACK;
        state_d    = ST_RESP;
`else
        state_d    = ST_IDLE;
`endif
      end
      ST_BUS_RD: begin
        bus_r_en = 1'b1;
        lat_d    = LAT_INIT;
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (lat_q == 2'd0) begin
          rsp_data_d = bus_rdata;
          state_d    = ST_RESP;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          // A count byte of 0 underflows to 255 here, giving 256 beats in total.
          beats_d = beats_q - 8'd1;
          if (beats_q != 8'd1) begin
            addr_d  = addr_q + 8'd1;
            state_d = ST_BUS_RD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_data    = rsp_data_q;
  assign bus_address = addr_q;
  assign bus_wdata   = wdata_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_io_bus_initiator.sv
// Self-checking bench for io_bus_initiator: scoreboarded responses and read addresses.
module tb_io_bus_initiator;
  import io_bus_pkg::*;

  localparam int RD_LAT = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] bus_address;
  logic [7:0] bus_wdata;
  logic       bus_w_en;
  logic       bus_r_en;
  logic [7:0] bus_rdata = 8'h00;
  logic       busy;
  state_e     dbg_state;

  int total = 0;
  int bad = 0;
  int r_cnt = 0;
  int w_cnt = 0;
  int rd_mode = 0;
  bit sb_en = 1'b1;
  bit raddr_check = 1'b1;
  logic [7:0] exp_q[$];
  logic [7:0] exp_raddr_q[$];

  io_bus_initiator #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .bus_address(bus_address), .bus_wdata(bus_wdata),
    .bus_w_en(bus_w_en), .bus_r_en(bus_r_en), .bus_rdata(bus_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and peripheral model: registered read data captured on the r_en edge.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_r_en) bus_rdata <= (rd_mode == 0) ? 8'hA5 : (bus_address ^ 8'h5A);
  end

  // Monitors
  always @(negedge clk) begin
    if (bus_r_en || bus_w_en) begin
      total++;
      if (bus_r_en && bus_w_en) begin
        bad++;
        $display("FAIL strobe_excl: r_en=%b w_en=%b required not both", bus_r_en, bus_w_en);
      end
    end
    if (bus_w_en) w_cnt++;
    if (bus_r_en) begin
      r_cnt++;
      if (raddr_check) begin
        total++;
        if (exp_raddr_q.size() == 0) begin
          bad++;
          $display("FAIL r_addr: unexpected r_en at addr %02h", bus_address);
        end else begin
          logic [7:0] ea;
          ea = exp_raddr_q.pop_front();
          if (bus_address !== ea) begin
            bad++;
            $display("FAIL r_addr: got %02h required %02h", bus_address, ea);
          end
        end
      end
    end
    if (sb_en && rsp_valid && rsp_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_data: unexpected response %02h", rsp_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rsp_data !== e) begin
          bad++;
          $display("FAIL rsp_data: got %02h required %02h", rsp_data, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 200);
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL cmd_accept: byte %02h not accepted within %0d cycles", b, n);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < 3000);
    total++;
    if (exp_q.size() != 0 || busy || exp_raddr_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending rsp=%0d raddr=%0d busy=%b required 0 0 0",
               exp_q.size(), exp_raddr_q.size(), busy);
    end
    @(posedge clk);
    #1;
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total += 3;
    if ({rsp_valid, bus_w_en, bus_r_en, busy, cmd_ready} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: rv/w/r/busy/crdy=%b required 00000",
               {rsp_valid, bus_w_en, bus_r_en, busy, cmd_ready});
    end
    if ({rsp_data, bus_address, bus_wdata} !== 24'h0) begin
      bad++;
      $display("FAIL reset_data: rsp/addr/wdata=%06h required 000000",
               {rsp_data, bus_address, bus_wdata});
    end
    if (dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    int w0;
    w0 = w_cnt;
`ifdef IO_BUS_WRITE_ACK_EN
    exp_q.push_back(RSP_ACK);
`endif
    send_byte(OP_WR);
    send_byte(8'h00);
    send_byte(8'hFF);
    @(negedge clk);
    total++;
    if ({bus_w_en, bus_address, bus_wdata} !== {1'b1, 8'h00, 8'hFF}) begin
      bad++;
      $display("FAIL write_strobe: w_en=%b addr=%02h wdata=%02h required 1 00 FF",
               bus_w_en, bus_address, bus_wdata);
    end
    @(negedge clk);
    total++;
    if (bus_w_en !== 1'b0) begin
      bad++;
      $display("FAIL write_one_cycle: w_en=%b required 0", bus_w_en);
    end
`ifndef IO_BUS_WRITE_ACK_EN
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL write_noack: busy=%b rsp_valid=%b required 0 0", busy, rsp_valid);
    end
`endif
    wait_idle();
    total++;
    if (w_cnt - w0 != 1) begin
      bad++;
      $display("FAIL write_count: got %0d required 1", w_cnt - w0);
    end
  endtask

  task automatic test_read();
    int n;
    rd_mode = 0;
    exp_q.push_back(8'hA5);
    exp_raddr_q.push_back(8'h01);
    send_byte(OP_RD);
    send_byte(8'h01);
    @(negedge clk);
    total++;
    if (bus_r_en !== 1'b1) begin
      bad++;
      $display("FAIL read_strobe: r_en=%b required 1", bus_r_en);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    total++;
    if (n != RD_LAT + 1) begin
      bad++;
      $display("FAIL read_latency: got %0d cycles required %0d", n, RD_LAT + 1);
    end
    wait_idle();
  endtask

  task automatic test_burst_wrap();
    rd_mode = 1;
    exp_q.push_back(8'hA4);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_raddr_q.push_back(8'hFE);
    exp_raddr_q.push_back(8'hFF);
    exp_raddr_q.push_back(8'h00);
    send_byte(OP_BRD);
    send_byte(8'hFE);
    send_byte(8'h03);
    wait_idle();
  endtask

  task automatic test_backpressure();
    int n;
    int r0;
    rd_mode = 1;
    rsp_ready = 1'b0;
    exp_q.push_back(8'h03 ^ 8'h5A);
    exp_raddr_q.push_back(8'h03);
    send_byte(OP_RD);
    send_byte(8'h03);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    r0 = r_cnt;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, rsp_data, cmd_ready, bus_r_en} !== {1'b1, 8'h59, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL hold_rsp: cyc=%0d valid=%b data=%02h crdy=%b r_en=%b required 1 59 0 0",
                 i, rsp_valid, rsp_data, cmd_ready, bus_r_en);
      end
      @(negedge clk);
    end
    total++;
    if (r_cnt != r0) begin
      bad++;
      $display("FAIL hold_no_read: got %0d extra r_en required 0", r_cnt - r0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_bad_opcode();
    int r0;
    int w0;
    r0 = r_cnt;
    w0 = w_cnt;
    exp_q.push_back(RSP_ERR);
    send_byte(8'h41);
    wait_idle();
    total++;
    if (r_cnt != r0 || w_cnt != w0) begin
      bad++;
      $display("FAIL bad_op_strobes: r=%0d w=%0d required 0 0", r_cnt - r0, w_cnt - w0);
    end
    rd_mode = 1;
    exp_q.push_back(8'h02 ^ 8'h5A);
    exp_raddr_q.push_back(8'h02);
    send_byte(OP_RD);
    send_byte(8'h02);
    wait_idle();
  endtask

  task automatic test_reset_mid_burst();
    int n;
    int seen;
    int r0;
    rd_mode = 1;
    sb_en = 1'b0;
    raddr_check = 1'b0;
    send_byte(OP_BRD);
    send_byte(8'h10);
    send_byte(8'h00);
    seen = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus_r_en) seen++;
    end while (seen < 3 && n < 300);
    total++;
    if (seen != 3) begin
      bad++;
      $display("FAIL burst_progress: got %0d beats required 3", seen);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total += 2;
    if ({rsp_valid, bus_w_en, bus_r_en, busy, cmd_ready} !== 5'b0) begin
      bad++;
      $display("FAIL midrst_ctrl: rv/w/r/busy/crdy=%b required 00000",
               {rsp_valid, bus_w_en, bus_r_en, busy, cmd_ready});
    end
    if ({rsp_data, bus_address, bus_wdata} !== 24'h0) begin
      bad++;
      $display("FAIL midrst_data: rsp/addr/wdata=%06h required 000000",
               {rsp_data, bus_address, bus_wdata});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r0 = r_cnt;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (r_cnt != r0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_quiet: r_en after reset=%0d busy=%b required 0 0", r_cnt - r0, busy);
    end
    exp_q.delete();
    exp_raddr_q.delete();
    sb_en = 1'b1;
    raddr_check = 1'b1;
    exp_q.push_back(8'h10 ^ 8'h5A);
    exp_raddr_q.push_back(8'h10);
    send_byte(OP_RD);
    send_byte(8'h10);
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_burst_wrap();
    test_backpressure();
    test_bad_opcode();
    test_reset_mid_burst();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
